// File: rtl/sha256_stream.sv
// Streaming SHA-256 front-end: packs byte beats into 512-bit blocks, pads, and drives one core.
// Define SHA256_STREAM_ABORT_EN to add the s_abort input for discarding a message in flight.
module sha256_stream #(
  parameter int DATA_W = 32,
  localparam int NB_W = $clog2(DATA_W/8) + 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SHA256_STREAM_ABORT_EN
  input  logic              s_abort,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [NB_W-1:0]   s_nbytes,
  input  logic              mode,
  output logic              core_init,
  output logic              core_next,
  output logic              core_mode,
  output logic [511:0]      core_block,
  input  logic              core_ready,
  input  logic [255:0]      core_digest,
  output logic [255:0]      digest,
  output logic              digest_valid,
  output logic              busy
);

  localparam int WPB   = 512 / DATA_W;
  localparam int BPB   = DATA_W / 8;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {EXTRA_NONE, EXTRA_LEN, EXTRA_PADLEN} extra_t;

  // Handshake: a beat transfers on a rising clk edge where s_valid && s_ready;
  // s_ready is high only in S_FILL, so beats offered during ISSUE/WAIT/DONE are held, not lost.

  state_t           state;
  extra_t           extra;
  logic [IDX_W-1:0] idx;
  logic [63:0]      len;
  logic             first;
  logic             final_blk;
  logic             hold_first;
  logic             abort_pend;
  logic             abort_c;

  logic [NB_W-1:0]   nb_c;
  logic [DATA_W-1:0] beat_c;
  logic [511:0]      fill_c;
  logic [511:0]      last_c;
  logic [63:0]       len_last_c;
  int                m_c;

`ifdef SHA256_STREAM_ABORT_EN
  assign abort_c = s_abort;
`else
  assign abort_c = 1'b0;
`endif

  assign s_ready = (state == S_FILL);

  // Block image after merging the current beat; the last beat also gets masking and padding.
  always_comb begin
    nb_c       = (s_nbytes > NB_W'(BPB)) ? NB_W'(BPB) : s_nbytes;
    beat_c     = s_data;
    fill_c     = core_block;
    last_c     = '0;
    m_c        = int'(idx) * BPB + int'(nb_c);
    len_last_c = len + 64'({nb_c, 3'b000});
    if (s_last) begin
      for (int b = 0; b < BPB; b++) begin
        if (b >= int'(nb_c)) beat_c[DATA_W-1-8*b -: 8] = 8'h00;
      end
    end
    for (int w = 0; w < WPB; w++) begin
      if (w == int'(idx)) fill_c[511-w*DATA_W -: DATA_W] = beat_c;
      else if (s_last && (w > int'(idx))) fill_c[511-w*DATA_W -: DATA_W] = '0;
    end
    last_c = fill_c;
    for (int b = 0; b < 64; b++) begin
      if (b == m_c) last_c[511-8*b -: 8] = 8'h80;
    end
    if (m_c <= 55) last_c[63:0] = len_last_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FILL;
      extra        <= EXTRA_NONE;
      idx          <= '0;
      len          <= '0;
      first        <= 1'b1;
      final_blk    <= 1'b0;
      hold_first   <= 1'b0;
      abort_pend   <= 1'b0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_mode    <= 1'b1;
      core_block   <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        S_FILL: begin
          if (abort_c) begin
            idx        <= '0;
            len        <= '0;
            first      <= 1'b1;
            busy       <= 1'b0;
            core_block <= '0;
            core_mode  <= 1'b1;
          end else if (s_valid) begin
            busy <= 1'b1;
            if (first && (idx == '0)) core_mode <= mode;
            if (s_last) begin
              core_block <= last_c;
              len        <= len_last_c;
              idx        <= '0;
              core_init  <= first;
              core_next  <= !first;
              state      <= S_ISSUE;
              if (m_c <= 55) begin
                final_blk <= 1'b1;
                extra     <= EXTRA_NONE;
              end else if (m_c <= 63) begin
                final_blk <= 1'b0;
                extra     <= EXTRA_LEN;
              end else begin
                final_blk <= 1'b0;
                extra     <= EXTRA_PADLEN;
              end
            end else begin
              core_block <= fill_c;
              len        <= len + 64'(DATA_W);
              if (idx == IDX_W'(WPB-1)) begin
                idx       <= '0;
                final_blk <= 1'b0;
                extra     <= EXTRA_NONE;
                core_init <= first;
                core_next <= !first;
                state     <= S_ISSUE;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
        end
        S_ISSUE: begin
          if (abort_c) abort_pend <= 1'b1;
          first      <= 1'b0;
          hold_first <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (abort_c) abort_pend <= 1'b1;
          // The core may still show its previous ready level for one cycle after the start pulse.
          if (hold_first) begin
            hold_first <= 1'b0;
          end else if (core_ready) begin
            if (abort_pend || abort_c) begin
              abort_pend <= 1'b0;
              idx        <= '0;
              len        <= '0;
              first      <= 1'b1;
              final_blk  <= 1'b0;
              extra      <= EXTRA_NONE;
              busy       <= 1'b0;
              core_block <= '0;
              core_mode  <= 1'b1;
              state      <= S_FILL;
            end else if (final_blk) begin
              state <= S_DONE;
            end else if (extra != EXTRA_NONE) begin
              core_block <= (extra == EXTRA_LEN) ? {448'b0, len} : {8'h80, 440'b0, len};
              final_blk  <= 1'b1;
              extra      <= EXTRA_NONE;
              core_next  <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_DONE: begin
          digest       <= core_digest;
          digest_valid <= 1'b1;
          len          <= '0;
          idx          <= '0;
          first        <= 1'b1;
          busy         <= 1'b0;
          state        <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: doc/sha256_stream.md
Name: sha256_stream

Overview:
- Streaming front-end for the sha256_top core. Accepts a byte-oriented message as DATA_W-bit beats over a valid/ready handshake.
- Assembles 512-bit blocks and performs all SHA-256 padding: the 0x80 byte, zero fill, and the 64-bit big-endian bit length.
- Sequences core_init/core_next pulses and returns the final digest with a one-cycle valid strobe.
- Sits between a DMA/bus adapter and one sha256_top instance.

Parameters:
- DATA_W, 32, input beat width in bits. Legal values: 8, 16, 32, 64, 128, 256, 512.
- Derived: WPB = 512/DATA_W words per block. NB_W = clog2(DATA_W/8)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block accepts a beat.
- s_data  in  DATA_W  message bytes; first byte in [DATA_W-1:DATA_W-8].
- s_last  in  1  final beat of the message.
- s_nbytes  in  NB_W  valid bytes in the beat. Sampled only when s_last=1. Range 0..DATA_W/8, left-justified.
- mode  in  1  core mode (1 = SHA-256). Sampled on the first accepted beat of a message.
- core_init  out  1  one-cycle start pulse for the first block.
- core_next  out  1  one-cycle start pulse for each later block.
- core_mode  out  1  latched mode.
- core_block  out  512  block presented to the core.
- core_ready  in  1  core idle.
- core_digest  in  256  core digest.
- digest  out  256  final digest register.
- digest_valid  out  1  one-cycle strobe when digest updates.
- busy  out  1  a message is in progress.

Behaviour:
- Reset: state=FILL, idx=0, len=0, first=1. s_ready=1. core_init=core_next=0, core_mode=1. core_block=0, digest=0, digest_valid=0, busy=0.
- FILL
  - s_ready=1.
  - Accepted non-last beat: written to word idx (word 0 at [511:512-DATA_W]); len += DATA_W; idx++.
  - idx reaching WPB: idx wraps to 0, go to ISSUE with final=0.
- Accepted last beat
  - Bytes at positions ≥ s_nbytes are zeroed; len += 8*s_nbytes.
  - m = idx*DATA_W/8 + s_nbytes (message bytes in this block).
  - Words above idx are cleared in the same cycle.
  - m ≤ 55: 0x80 placed at byte m, len placed in bytes 56–63, ISSUE with final=1.
  - 56 ≤ m ≤ 63: 0x80 placed at byte m, ISSUE with final=0, extra=LEN.
  - m = 64: block issued unchanged, ISSUE with final=0, extra=PADLEN.
- ISSUE (1 cycle)
  - core_init if first=1, else core_next; then first=0.
  - s_ready=0. Go to WAIT.
- WAIT
  - core_ready is ignored in the first cycle, then the block waits for core_ready=1.
  - On core_ready=1:
    - final=1: go to DONE.
    - extra≠0: build the extra block in one cycle, go to ISSUE with final=1, extra=0.
    - LEN extra block: zeros plus len.
    - PADLEN extra block: 0x80 at byte 0, zeros, len.
    - otherwise: go to FILL.
- DONE (1 cycle)
  - digest <= core_digest, digest_valid=1.
  - len=0, idx=0, first=1. Go to FILL.
- Widths and stream rules:
  - len is 64 bits and wraps modulo 2^64.
  - s_nbytes=0 with s_last is the empty message.
  - s_nbytes > DATA_W/8 is treated as DATA_W/8.
- busy: 1 from the first accepted beat until the DONE cycle inclusive.
- Holding: core_block and core_mode are held stable from ISSUE until the core returns ready.
- s_valid without an accepted beat has no effect; data is never lost under backpressure.
- Reset mid-message returns every register to reset values. The core must share the same reset source, inverted, on reset_n.

Optional Feature:
- Macro SHA256_STREAM_ABORT_EN adds input s_abort (1 bit).
- s_abort=1 in FILL: discards the partial message and returns to the reset-equivalent FILL state with digest held.
- s_abort=1 in ISSUE/WAIT: sets a pending flag. When core_ready returns, the block goes to FILL without DONE and without digest_valid.
- s_abort takes priority over a simultaneous accepted beat, and that beat is dropped.
- Without the macro the port does not exist and messages always complete.

Test Plan:
- DATA_W=32, beat 0x61626300, nbytes=3, last, mode=1 → core_block 61626380_0…0_00000018, one core_init pulse, digest BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD, digest_valid high exactly 1 cycle.
- Empty message (nbytes=0, last) → core_block 80000000_0…0, digest E3B0C44298FC1C149AFBF4C8996FB92427AE41E4649B934CA495991B7852B855.
- 56-byte "abcdbcdecdefdefg…nopq" (14 beats) → core_init then core_next, second block all zero except length 0x1C0, digest 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1.
- 64-byte message (m=64) → second block 80000000_0…0_00000200; exactly 2 start pulses; digest matches a software model.
- s_valid held high through WAIT → s_ready=0, no beat consumed. Reset asserted mid-WAIT → all outputs at reset values next cycle; a following "abc" run still returns BA7816BF…15AD.
- With SHA256_STREAM_ABORT_EN: s_abort during WAIT of block 1 of a 9-block message → no digest_valid. A following "abc" message yields the correct digest.
